// File: rtl/lfsr_gen_if.sv
// Seed/advance handshake and LFSR output bundle for lfsr_gen.
// master = stimulus side, slave = lfsr_gen.
interface lfsr_gen_if #(
  parameter int WIDTH = 16
);
  logic             seed_valid;
  logic [WIDTH-1:0] seed;
  logic             seed_ready;
  logic             advance;
  logic [WIDTH-1:0] shift_seed;
  logic             rand_valid;
  logic             lockup;
  logic [31:0]      step_count;

  modport master (
    output seed_valid, seed, advance,
    input  seed_ready, shift_seed, rand_valid, lockup, step_count
  );

  modport slave (
    input  seed_valid, seed, advance,
    output seed_ready, shift_seed, rand_valid, lockup, step_count
  );
endinterface

// File: rtl/lfsr_gen.sv
// Seedable XNOR Fibonacci LFSR, STEPS shifts per advance, with lock-up recovery.
// Optional step counter is built only when LFSR_GEN_COUNT_EN is defined.
module lfsr_gen #(
  parameter int WIDTH = 16,
  parameter int STEPS = 1
) (
  input  logic  clk,
  input  logic  reset,
  lfsr_gen_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Tap masks use 0-based bit indices (1-based tap position minus one).
  localparam logic [63:0] TAP_MASK =
      (WIDTH == 8)  ? 64'h0000_0000_0000_00B8 :
      (WIDTH == 16) ? 64'h0000_0000_0000_D008 :
      (WIDTH == 32) ? 64'h0000_0000_8020_0003 :
                      64'hD800_0000_0000_0000;
  localparam logic [WIDTH-1:0] TAPS     = TAP_MASK[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  if (!((WIDTH == 8) || (WIDTH == 16) || (WIDTH == 32) || (WIDTH == 64))) begin : g_bad_width
    $error("lfsr_gen: WIDTH must be 8, 16, 32 or 64");
  end
  if ((STEPS < 1) || (STEPS > 8)) begin : g_bad_steps
    $error("lfsr_gen: STEPS must be in 1..8");
  end

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             rv_q, rv_d;
  logic             lockup_q, lockup_d;
  logic [WIDTH-1:0] stepped_s;
  logic             seed_accept_s;
  logic             adv_accept_s;
  logic             seed_ready_s;

  // Ready follows reset directly so it drops the instant reset asserts.
  assign seed_ready_s  = reset;
  assign seed_accept_s = bus.seed_valid & seed_ready_s;
  assign adv_accept_s  = bus.advance & ~seed_accept_s & (state_q == ST_RUN);

  // Apply STEPS single XNOR shifts to the current state.
  always_comb begin
    stepped_s = shift_q;
    for (int i = 0; i < STEPS; i++) begin
      stepped_s = {stepped_s[WIDTH-2:0], ~(^(stepped_s & TAPS))};
    end
  end

  // Next-state logic: seed load beats advance; all-ones is the XNOR dead state.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    rv_d     = rv_q;
    lockup_d = 1'b0;
    if (seed_accept_s) begin
      state_d = ST_RUN;
      rv_d    = 1'b1;
      if (bus.seed == ALL_ONES) begin
        shift_d  = {bus.seed[WIDTH-1:1], 1'b0};
        lockup_d = 1'b1;
      end else begin
        shift_d  = bus.seed;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          shift_d = shift_q;
        end
        ST_RUN: begin
          if (shift_q == ALL_ONES) begin
            shift_d  = {WIDTH{1'b0}};
            lockup_d = 1'b1;
          end else if (bus.advance) begin
            shift_d = stepped_s;
          end else begin
            shift_d = shift_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          shift_d = {WIDTH{1'b0}};
          rv_d    = 1'b0;
        end
      endcase
    end
  end

  // Core state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      shift_q  <= {WIDTH{1'b0}};
      rv_q     <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      rv_q     <= rv_d;
      lockup_q <= lockup_d;
    end
  end

`ifdef LFSR_GEN_COUNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Counter clears on seed load and wraps naturally at 2^32.
  always_comb begin
    if (seed_accept_s) begin
      cnt_d = 32'd0;
    end else if (adv_accept_s) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Step counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.step_count = cnt_q;
`else
  logic unused_adv_s;
  assign unused_adv_s   = adv_accept_s;
  assign bus.step_count = 32'd0;
`endif

  assign bus.seed_ready = seed_ready_s;
  assign bus.shift_seed = shift_q;
  assign bus.rand_valid = rv_q;
  assign bus.lockup     = lockup_q;

endmodule
